// File: rtl/mor1kx_l15_rr_arbiter_if.sv
// mor1kx_l15_rr_arbiter_if: transducer<->L1.5 link; master = request driver/response sink (transducer side), slave = request sink/response driver (L1.5 side)
interface mor1kx_l15_rr_arbiter_if;
  logic        val;
  logic [4:0]  rqtype;
  logic [3:0]  amo_op;
  logic        nc;
  logic [2:0]  size;
  logic [1:0]  l1rplway;
  logic [39:0] address;
  logic [63:0] data;
  logic        req_ack;
  logic        header_ack;
  logic        ack;
  logic        resp_val;
  logic [3:0]  returntype;
  logic [1:0]  error;
  logic        noncacheable;
  logic [63:0] data_0;
  logic [63:0] data_1;
  logic [63:0] data_2;
  logic [63:0] data_3;
  modport master (
    output val, rqtype, amo_op, nc, size, l1rplway, address, data, req_ack,
    input  header_ack, ack, resp_val, returntype, error, noncacheable, data_0, data_1, data_2, data_3
  );
  modport slave (
    input  val, rqtype, amo_op, nc, size, l1rplway, address, data, req_ack,
    output header_ack, ack, resp_val, returntype, error, noncacheable, data_0, data_1, data_2, data_3
  );
endinterface

// File: rtl/mor1kx_l15_rr_arbiter.sv
// mor1kx_l15_rr_arbiter: round-robin share of one L1.5 port between icache/dcache (slave links) toward l15 (master link), one transaction at a time; clk, rst, arb_owner/arb_busy/arb_timeout status
module mor1kx_l15_rr_arbiter #(
  parameter bit RESET_LAST  = 1'b1,
  parameter int TIMEOUT_CYC = 0,
  parameter int TO_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  mor1kx_l15_rr_arbiter_if.slave         icache,
  mor1kx_l15_rr_arbiter_if.slave         dcache,
  mor1kx_l15_rr_arbiter_if.master        l15,
  output logic                           arb_owner,
  output logic                           arb_busy,
  output logic                           arb_timeout
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic owner, pick, any_val, own_val, own_req_ack, in_req, in_resp;
  logic [TO_W-1:0] cnt;
  assign any_val     = icache.val || dcache.val;
  assign pick        = (icache.val && dcache.val) ? !owner : dcache.val;
  assign own_val     = owner ? dcache.val : icache.val;
  assign own_req_ack = owner ? dcache.req_ack : icache.req_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= RESET_LAST;
      cnt         <= '0;
      arb_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_val) owner <= pick;
      cnt <= (state == RESP) ? cnt + TO_W'(cnt != '1) : '0;
      if (TIMEOUT_CYC != 0 && state == RESP && cnt == TO_W'(TIMEOUT_CYC)) arb_timeout <= 1'b1;
    end
  end
  always_comb begin
    state_nx = (state == IDLE) ? (any_val ? REQ : IDLE)
             : (state == REQ)  ? ((l15.header_ack && own_val) ? RESP : (own_val ? REQ : IDLE))
             : (state == RESP) ? ((l15.resp_val && own_req_ack) ? IDLE : RESP)
             : IDLE;
  end
  always_comb begin
    in_req             = !rst && state == REQ;
    in_resp            = !rst && state == RESP;
    l15.val            = in_req && own_val;
    l15.rqtype         = owner ? dcache.rqtype : icache.rqtype;
    l15.nc             = owner ? dcache.nc : icache.nc;
    l15.size           = owner ? dcache.size : icache.size;
    l15.l1rplway       = owner ? dcache.l1rplway : icache.l1rplway;
    l15.address        = owner ? dcache.address : icache.address;
    l15.amo_op         = owner ? dcache.amo_op : '0;
    l15.data           = owner ? dcache.data : '0;
    l15.req_ack        = !rst && (in_resp ? own_req_ack : dcache.req_ack);
    icache.header_ack  = in_req && !owner && l15.header_ack;
    dcache.header_ack  = in_req && owner && l15.header_ack;
    icache.ack         = (in_req || in_resp) && !owner && l15.ack;
    dcache.ack         = (in_req || in_resp) && owner && l15.ack;
    icache.resp_val    = in_resp && !owner && l15.resp_val;
    dcache.resp_val    = !rst && l15.resp_val && (state != RESP || owner);
    arb_owner          = owner;
    arb_busy           = state != IDLE;
  end
  assign icache.returntype   = l15.returntype;
  assign icache.error        = l15.error;
  assign icache.noncacheable = l15.noncacheable;
  assign icache.data_0       = l15.data_0;
  assign icache.data_1       = l15.data_1;
  assign icache.data_2       = l15.data_2;
  assign icache.data_3       = l15.data_3;
  assign dcache.returntype   = l15.returntype;
  assign dcache.error        = l15.error;
  assign dcache.noncacheable = l15.noncacheable;
  assign dcache.data_0       = l15.data_0;
  assign dcache.data_1       = l15.data_1;
  assign dcache.data_2       = l15.data_2;
  assign dcache.data_3       = l15.data_3;
endmodule

// File: tb/tb_mor1kx_l15_rr_arbiter.sv
// tb_mor1kx_l15_rr_arbiter: directed bench with response/grant scoreboards for the L1.5 round-robin arbiter
module tb_mor1kx_l15_rr_arbiter;
  logic clk, rst, arb_owner, arb_busy, arb_timeout;
  int errors = 0;
  int checks = 0;
  typedef struct {bit tgt; logic [63:0] d;} rsp_t;
  rsp_t rq[$];
  bit gq[$];
  mor1kx_l15_rr_arbiter_if ic();
  mor1kx_l15_rr_arbiter_if dc();
  mor1kx_l15_rr_arbiter_if l15();
  mor1kx_l15_rr_arbiter #(.RESET_LAST(1'b1), .TIMEOUT_CYC(8), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .icache(ic), .dcache(dc), .l15(l15),
    .arb_owner(arb_owner), .arb_busy(arb_busy), .arb_timeout(arb_timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    if (!rst && (ic.resp_val === 1'b1 || dc.resp_val === 1'b1)) begin
      check("resp_pending", 64'(rq.size() != 0), 64'(1));
      if (rq.size() != 0) begin
        rsp_t r;
        r = rq.pop_front();
        check("resp_route", 64'({ic.resp_val, dc.resp_val}), r.tgt ? 64'b01 : 64'b10);
        check("resp_data", r.tgt ? dc.data_0 : ic.data_0, r.d);
      end
    end
  end
  task automatic serve(input logic [63:0] d, input bit drop);
    bit eo;
    eo = gq.pop_front();
    for (int i = 0; i < 20 && l15.val !== 1'b1; i++) cyc();
    check("grant_val", 64'(l15.val), 64'(1));
    check("grant_owner", 64'(arb_owner), 64'(eo));
    check("grant_addr", 64'(l15.address), 64'(eo ? dc.address : ic.address));
    check("grant_amo", 64'(l15.amo_op), 64'(eo ? dc.amo_op : 4'h0));
    check("grant_data", l15.data, eo ? dc.data : 64'h0);
    l15.header_ack = 1'b1;
    l15.ack = 1'b1;
    #1;
    check("hdr_ack_i", 64'(ic.header_ack), 64'(!eo));
    check("hdr_ack_d", 64'(dc.header_ack), 64'(eo));
    check("ack_i", 64'(ic.ack), 64'(!eo));
    cyc();
    l15.header_ack = 1'b0;
    l15.ack = 1'b0;
    if (drop) begin
      if (eo) dc.val = 1'b0;
      else ic.val = 1'b0;
    end
    #1;
    check("resp_l15_val", 64'(l15.val), 64'(0));
    check("resp_busy", 64'(arb_busy), 64'(1));
    rq.push_back('{tgt: eo, d: d});
    l15.resp_val = 1'b1;
    l15.data_0 = d;
    ic.req_ack = 1'b1;
    dc.req_ack = 1'b1;
    #1;
    check("req_ack_fwd", 64'(l15.req_ack), 64'(1));
    cyc();
    l15.resp_val = 1'b0;
    ic.req_ack = 1'b0;
    dc.req_ack = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    {ic.val, ic.rqtype, ic.amo_op, ic.nc, ic.size, ic.l1rplway, ic.address, ic.data, ic.req_ack} = '0;
    {dc.val, dc.rqtype, dc.amo_op, dc.nc, dc.size, dc.l1rplway, dc.address, dc.data, dc.req_ack} = '0;
    {l15.header_ack, l15.ack, l15.resp_val, l15.returntype, l15.error, l15.noncacheable} = '0;
    {l15.data_0, l15.data_1, l15.data_2, l15.data_3} = '0;
    ic.address = 40'h00_0000_1000;
    ic.rqtype = 5'h10;
    dc.address = 40'h00_0000_2000;
    dc.rqtype = 5'h01;
    dc.amo_op = 4'h5;
    dc.data = 64'hD00D_F00D_1234_5678;
    cyc();
    cyc();
    check("rst_busy", 64'(arb_busy), 64'(0));
    check("rst_owner", 64'(arb_owner), 64'(1));
    check("rst_timeout", 64'(arb_timeout), 64'(0));
    check("rst_l15_val", 64'(l15.val), 64'(0));
    // single icache transaction
    rst = 1'b0;
    ic.val = 1'b1;
    #1;
    check("t1_idle_latency", 64'(l15.val), 64'(0));
    gq.push_back(1'b0);
    cyc();
    check("t1_cycle2_val", 64'(l15.val), 64'(1));
    check("t1_rqtype", 64'(l15.rqtype), 64'(5'h10));
    serve(64'hAAAA_0001, 1'b1);
    // both requesting: alternating grants
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ic.val = 1'b1;
    dc.val = 1'b1;
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    serve(64'hB000_0001, 1'b0);
    serve(64'hB000_0002, 1'b0);
    serve(64'hB000_0003, 1'b0);
    serve(64'hB000_0004, 1'b0);
    ic.val = 1'b0;
    dc.val = 1'b0;
    cyc();
    // dcache owns the port, icache waits
    dc.val = 1'b1;
    cyc();
    check("t3_d_grant", 64'(l15.val), 64'(1));
    check("t3_d_owner", 64'(arb_owner), 64'(1));
    l15.header_ack = 1'b1;
    cyc();
    l15.header_ack = 1'b0;
    dc.val = 1'b0;
    ic.val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_hold_owner", 64'({arb_owner, arb_busy, l15.val}), 64'(3'b110));
      cyc();
    end
    rq.push_back('{tgt: 1'b1, d: 64'hC0DE_0001});
    l15.resp_val = 1'b1;
    l15.data_0 = 64'hC0DE_0001;
    ic.req_ack = 1'b1;
    cyc();
    check("t3_wrong_ack_holds", 64'({arb_owner, arb_busy}), 64'(2'b11));
    rq.push_back('{tgt: 1'b1, d: 64'hC0DE_0001});
    dc.req_ack = 1'b1;
    cyc();
    l15.resp_val = 1'b0;
    ic.req_ack = 1'b0;
    dc.req_ack = 1'b0;
    #1;
    check("t3_idle_gap", 64'({arb_busy, l15.val}), 64'(0));
    cyc();
    check("t3_i_grant", 64'({arb_owner, l15.val}), 64'(2'b01));
    gq.push_back(1'b0);
    serve(64'hC0DE_0002, 1'b1);
    check("t3_no_timeout", 64'(arb_timeout), 64'(0));
    // invalidation in IDLE goes to dcache
    rq.push_back('{tgt: 1'b1, d: 64'h1AB0_0001});
    l15.resp_val = 1'b1;
    l15.data_0 = 64'h1AB0_0001;
    dc.req_ack = 1'b1;
    #1;
    check("t4_d_val", 64'(dc.resp_val), 64'(1));
    check("t4_i_val", 64'(ic.resp_val), 64'(0));
    check("t4_req_ack", 64'(l15.req_ack), 64'(1));
    cyc();
    check("t4_idle", 64'(arb_busy), 64'(0));
    l15.resp_val = 1'b0;
    dc.req_ack = 1'b0;
    // watchdog
    ic.val = 1'b1;
    cyc();
    check("t5_grant", 64'(l15.val), 64'(1));
    l15.header_ack = 1'b1;
    cyc();
    l15.header_ack = 1'b0;
    ic.val = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("t5_early", 64'(arb_timeout), 64'(0));
    for (int i = 0; i < 8; i++) cyc();
    check("t5_timeout", 64'(arb_timeout), 64'(1));
    check("t5_still_busy", 64'(arb_busy), 64'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t5_rst_clear", 64'({arb_timeout, arb_busy, arb_owner}), 64'(3'b001));
    // reset in REQ
    ic.val = 1'b1;
    cyc();
    check("t6_req", 64'({l15.val, arb_owner}), 64'(2'b10));
    rst = 1'b1;
    l15.header_ack = 1'b1;
    l15.ack = 1'b1;
    #1;
    check("t6_gated", 64'({ic.header_ack, ic.ack, dc.header_ack, dc.ack, l15.val}), 64'(0));
    cyc();
    check("t6_rst_state", 64'({l15.val, arb_busy, arb_owner}), 64'(3'b001));
    check("t6_gated_after", 64'({ic.header_ack, ic.ack, dc.header_ack, dc.ack}), 64'(0));
    rst = 1'b0;
    l15.header_ack = 1'b0;
    l15.ack = 1'b0;
    ic.val = 1'b0;
    cyc();
    cyc();
    check("sb_drained", 64'(rq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
